dut_req_arb: RTL and testbench

DUT_REQ_ARB -- requirements
Module: dut_req_arb

---
 rtl/dut_req_arb.sv | 184 ++++++++++++++++++
 tb/tb_dut_req_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_req_arb.sv
// Two-requester round-robin front end for a shared ALU.
// Each transaction: one grant/start pulse, a wait for the ALU response or a timeout, then one done pulse.
module dut_req_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        r0_req,
    input  logic [31:0] r0_A,
    input  logic [31:0] r0_B,
    input  logic [7:0]  r0_op,
    input  logic        r0_op_pf,
    input  logic        r0_sv,
    input  logic        r1_req,
    input  logic [31:0] r1_A,
    input  logic [31:0] r1_B,
    input  logic [7:0]  r1_op,
    input  logic        r1_op_pf,
    input  logic        r1_sv,
    output logic        r0_gnt,
    output logic        r1_gnt,
    output logic        r0_done,
    output logic        r1_done,
    output logic [63:0] r0_result,
    output logic [63:0] r1_result,
    output logic [7:0]  r0_err,
    output logic [7:0]  r1_err,
    output logic        dut_start,
    output logic [31:0] dut_A,
    output logic [31:0] dut_B,
    output logic [7:0]  dut_op,
    output logic        dut_op_pf,
    output logic        dut_sv,
    input  logic        dut_done,
    input  logic [63:0] dut_result,
    input  logic [7:0]  dut_err,
    output logic        busy,
    output logic        tmo
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RES_W  = 64;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_TMO  = ERR_W'(8'hFF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic              op_pf;
        logic              sv;
    } cmd_t;

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RES_W-1:0]  r0_result_d, r1_result_d;
    logic [ERR_W-1:0]  r0_err_d, r1_err_d;
    logic              tmo_d;
    logic              start_d;
    logic              winner;

    // Tie goes to whoever was not served last.
    assign winner = (r0_req && r1_req) ? ~last_q : r1_req;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        r0_result_d = r0_result;
        r1_result_d = r1_result;
        r0_err_d    = r0_err;
        r1_err_d    = r1_err;
        tmo_d       = tmo;

        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    owner_d = winner;
                    cmd_d   = winner ? cmd_t'{r1_A, r1_B, r1_op, r1_op_pf, r1_sv}
                                     : cmd_t'{r0_A, r0_B, r0_op, r0_op_pf, r0_sv};
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (dut_done) begin
                    if (owner_q) begin
                        r1_result_d = dut_result;
                        r1_err_d    = dut_err;
                    end else begin
                        r0_result_d = dut_result;
                        r0_err_d    = dut_err;
                    end
                    state_d = RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    if (owner_q) begin
                        r1_result_d = '0;
                        r1_err_d    = ERR_TMO;
                    end else begin
                        r0_result_d = '0;
                        r0_err_d    = ERR_TMO;
                    end
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        start_d = (state_d == ISSUE);
    end

    // Pulse outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            r0_result <= '0;
            r1_result <= '0;
            r0_err    <= '0;
            r1_err    <= '0;
            tmo       <= 1'b0;
            dut_start <= 1'b0;
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_done   <= 1'b0;
            r1_done   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            r0_result <= r0_result_d;
            r1_result <= r1_result_d;
            r0_err    <= r0_err_d;
            r1_err    <= r1_err_d;
            tmo       <= tmo_d;
            dut_start <= start_d;
            r0_gnt    <= start_d && !owner_d;
            r1_gnt    <= start_d && owner_d;
            r0_done   <= (state_d == RESP) && !owner_d;
            r1_done   <= (state_d == RESP) && owner_d;
            busy      <= (state_d != IDLE);
        end
    end

    assign dut_A     = cmd_q.a;
    assign dut_B     = cmd_q.b;
    assign dut_op    = cmd_q.op;
    assign dut_op_pf = cmd_q.op_pf;
    assign dut_sv    = cmd_q.sv;

endmodule

// File: tb/tb_dut_req_arb.sv
// Directed bench for dut_req_arb built with TIMEOUT=4; the shared-ALU response is driven by hand.
module tb_dut_req_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r0_req, r1_req;
    logic [31:0] r0_A, r0_B, r1_A, r1_B;
    logic [7:0]  r0_op, r1_op;
    logic        r0_op_pf, r0_sv, r1_op_pf, r1_sv;
    logic        r0_gnt, r1_gnt, r0_done, r1_done;
    logic [63:0] r0_result, r1_result;
    logic [7:0]  r0_err, r1_err;
    logic        dut_start;
    logic [31:0] dut_A, dut_B;
    logic [7:0]  dut_op;
    logic        dut_op_pf, dut_sv;
    logic        dut_done;
    logic [63:0] dut_result;
    logic [7:0]  dut_err;
    logic        busy, tmo;

    int vecs = 0;
    int errs = 0;

    dut_req_arb #(.TIMEOUT(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .r0_req(r0_req), .r0_A(r0_A), .r0_B(r0_B), .r0_op(r0_op), .r0_op_pf(r0_op_pf), .r0_sv(r0_sv),
        .r1_req(r1_req), .r1_A(r1_A), .r1_B(r1_B), .r1_op(r1_op), .r1_op_pf(r1_op_pf), .r1_sv(r1_sv),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_done(r0_done), .r1_done(r1_done),
        .r0_result(r0_result), .r1_result(r1_result), .r0_err(r0_err), .r1_err(r1_err),
        .dut_start(dut_start), .dut_A(dut_A), .dut_B(dut_B), .dut_op(dut_op),
        .dut_op_pf(dut_op_pf), .dut_sv(dut_sv),
        .dut_done(dut_done), .dut_result(dut_result), .dut_err(dut_err),
        .busy(busy), .tmo(tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        r0_req = 0; r1_req = 0;
        r0_A = 0; r0_B = 0; r0_op = 0; r0_op_pf = 0; r0_sv = 0;
        r1_A = 0; r1_B = 0; r1_op = 0; r1_op_pf = 0; r1_sv = 0;
        dut_done = 0; dut_result = 0; dut_err = 0;
        tick(); tick();
        vecs++;
        if ({r0_gnt, r1_gnt, r0_done, r1_done, dut_start, busy, tmo} !== 7'b0) begin
            errs++; $display("FAIL reset_ctrl: got %b want 0", {r0_gnt, r1_gnt, r0_done, r1_done, dut_start, busy, tmo});
        end
        vecs++;
        if ({r0_result, r1_result, r0_err, r1_err} !== 144'b0) begin
            errs++; $display("FAIL reset_results: got %h want 0", {r0_result, r1_result, r0_err, r1_err});
        end
        vecs++;
        if ({dut_A, dut_B, dut_op, dut_op_pf, dut_sv} !== 74'b0) begin
            errs++; $display("FAIL reset_cmd: got %h want 0", {dut_A, dut_B, dut_op, dut_op_pf, dut_sv});
        end
        reset_n = 1'b1;
        tick();
        vecs++;
        if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        r0_A = 32'd5; r0_B = 32'd3; r0_op = 8'h01; r0_op_pf = 1'b1; r0_sv = 1'b0;
        r0_req = 1'b1;
        tick();
        vecs++;
        if ({r0_gnt, r1_gnt, dut_start, busy} !== 4'b1011) begin
            errs++; $display("FAIL single_grant: got %b want 1011", {r0_gnt, r1_gnt, dut_start, busy});
        end
        vecs++;
        if ({dut_A, dut_B, dut_op, dut_op_pf, dut_sv} !== {32'd5, 32'd3, 8'h01, 1'b1, 1'b0}) begin
            errs++; $display("FAIL single_cmd: got %h/%h/%h want 5/3/01", dut_A, dut_B, dut_op);
        end
        tick();
        vecs++;
        if ({r0_gnt, dut_start, busy} !== 3'b001) begin
            errs++; $display("FAIL single_pulse_width: got %b want 001", {r0_gnt, dut_start, busy});
        end
        tick();
        dut_done = 1'b1; dut_result = 64'd8; dut_err = 8'h00;
        tick();
        dut_done = 1'b0; dut_result = 64'hDEAD;
        vecs++;
        if ({r0_done, r1_done} !== 2'b10) begin
            errs++; $display("FAIL single_done: got %b want 10", {r0_done, r1_done});
        end
        vecs++;
        if (r0_result !== 64'd8 || r0_err !== 8'h00) begin
            errs++; $display("FAIL single_result: got %0d/%h want 8/00", r0_result, r0_err);
        end
        vecs++;
        if (dut_A !== 32'd5) begin errs++; $display("FAIL single_cmd_resp: got %0d want 5", dut_A); end
        r0_req = 1'b0;
        tick();
        vecs++;
        if ({r0_done, busy} !== 2'b00) begin
            errs++; $display("FAIL single_back_idle: got %b want 00", {r0_done, busy});
        end
    endtask

    task automatic test_round_robin();
        logic [63:0] exp_r0, exp_r1;
        logic [1:0]  exp_gnt;
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        exp_r0 = 64'd0; exp_r1 = 64'd0;
        r0_A = 32'd10; r1_A = 32'd20;
        r0_req = 1'b1; r1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            vecs++;
            if ({r1_gnt, r0_gnt} !== exp_gnt) begin
                errs++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {r1_gnt, r0_gnt}, exp_gnt);
            end
            vecs++;
            if (dut_A !== ((i % 2 == 0) ? 32'd10 : 32'd20)) begin
                errs++; $display("FAIL rr_cmd[%0d]: got %0d", i, dut_A);
            end
            tick();
            dut_done = 1'b1; dut_result = 64'd100 + 64'(i); dut_err = 8'(i);
            tick();
            dut_done = 1'b0;
            if (i % 2 == 0) exp_r0 = 64'd100 + 64'(i);
            else            exp_r1 = 64'd100 + 64'(i);
            vecs++;
            if ({r1_done, r0_done} !== exp_gnt) begin
                errs++; $display("FAIL rr_done[%0d]: got %b want %b", i, {r1_done, r0_done}, exp_gnt);
            end
            vecs++;
            if (r0_result !== exp_r0 || r1_result !== exp_r1) begin
                errs++; $display("FAIL rr_results[%0d]: got %0d/%0d want %0d/%0d", i, r0_result, r1_result, exp_r0, exp_r1);
            end
            tick();
        end
        r0_req = 1'b0; r1_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        r1_A = 32'd7;
        r1_req = 1'b1;
        tick();
        vecs++;
        if ({r1_gnt, r0_gnt, dut_start} !== 3'b101) begin
            errs++; $display("FAIL tmo_grant: got %b want 101", {r1_gnt, r0_gnt, dut_start});
        end
        for (int w = 0; w < 4; w++) begin
            tick();
            vecs++;
            if ({r1_done, tmo} !== 2'b00) begin
                errs++; $display("FAIL tmo_wait[%0d]: got %b want 00", w, {r1_done, tmo});
            end
        end
        tick();
        vecs++;
        if ({r1_done, tmo} !== 2'b11) begin
            errs++; $display("FAIL tmo_done: got %b want 11", {r1_done, tmo});
        end
        vecs++;
        if (r1_err !== 8'hFF || r1_result !== 64'd0) begin
            errs++; $display("FAIL tmo_result: got %h/%h want FF/0", r1_err, r1_result);
        end
        vecs++;
        if (r0_result !== 64'd102 || r0_err !== 8'd2) begin
            errs++; $display("FAIL tmo_other_hold: got %0d/%0d want 102/2", r0_result, r0_err);
        end
        r1_req = 1'b0;
        tick(); tick();
        vecs++;
        if ({tmo, busy} !== 2'b10) begin
            errs++; $display("FAIL tmo_sticky: got %b want 10", {tmo, busy});
        end
    endtask

    task automatic test_reset_mid();
        r0_A = 32'd9;
        r0_req = 1'b1;
        tick(); tick();
        r0_req = 1'b0;
        reset_n = 1'b0;
        #1;
        vecs++;
        if ({r0_gnt, r1_gnt, r0_done, r1_done, dut_start, busy, tmo} !== 7'b0) begin
            errs++; $display("FAIL rstmid_ctrl: got %b want 0", {r0_gnt, r1_gnt, r0_done, r1_done, dut_start, busy, tmo});
        end
        vecs++;
        if ({r0_result, r1_result, r0_err, r1_err, dut_A} !== 176'b0) begin
            errs++; $display("FAIL rstmid_data: got %h want 0", {r0_result, r1_result, r0_err, r1_err, dut_A});
        end
        tick();
        reset_n = 1'b1;
        dut_done = 1'b1; dut_result = 64'd55; dut_err = 8'h3;
        tick();
        vecs++;
        if ({r0_done, r1_done, busy} !== 3'b000 || r0_result !== 64'd0) begin
            errs++; $display("FAIL rstmid_late_done: got %b/%0d want 000/0", {r0_done, r1_done, busy}, r0_result);
        end
    endtask

    task automatic test_ignore_done();
        dut_done = 1'b1; dut_result = 64'd66;
        tick(); tick();
        vecs++;
        if ({busy, r0_done, r1_done} !== 3'b000 || r0_result !== 64'd0 || r0_err !== 8'd0) begin
            errs++; $display("FAIL idle_done_ignored: got %b/%0d want 000/0", {busy, r0_done, r1_done}, r0_result);
        end
        dut_done = 1'b0;
        r0_req = 1'b1;
        tick();
        dut_done = 1'b1; dut_result = 64'd99;
        tick();
        dut_done = 1'b0;
        vecs++;
        if ({busy, r0_done, dut_start} !== 3'b100 || r0_result !== 64'd0) begin
            errs++; $display("FAIL issue_done_ignored: got %b/%0d want 100/0", {busy, r0_done, dut_start}, r0_result);
        end
        dut_done = 1'b1; dut_result = 64'd77; dut_err = 8'h11;
        tick();
        dut_done = 1'b0;
        vecs++;
        if (r0_done !== 1'b1 || r0_result !== 64'd77 || r0_err !== 8'h11) begin
            errs++; $display("FAIL issue_then_wait_done: got %b/%0d/%h want 1/77/11", r0_done, r0_result, r0_err);
        end
        r0_req = 1'b0;
        tick();
    endtask

    task automatic test_stable_and_drop();
        r0_A = 32'h1111; r0_B = 32'h0A0A;
        r0_req = 1'b1;
        tick();
        tick();
        r0_A = 32'h2222; r0_B = 32'h0B0B;
        r1_req = 1'b1;
        tick();
        r1_req = 1'b0;
        vecs++;
        if (dut_A !== 32'h1111 || dut_B !== 32'h0A0A) begin
            errs++; $display("FAIL stable_wait: got %h/%h want 1111/0A0A", dut_A, dut_B);
        end
        dut_done = 1'b1; dut_result = 64'd1;
        tick();
        dut_done = 1'b0;
        r0_req = 1'b0;
        vecs++;
        if (dut_A !== 32'h1111 || r0_done !== 1'b1) begin
            errs++; $display("FAIL stable_resp: got %h/%b want 1111/1", dut_A, r0_done);
        end
        tick(); tick();
        vecs++;
        if ({r1_gnt, r0_gnt, dut_start, busy} !== 4'b0000) begin
            errs++; $display("FAIL drop_no_grant: got %b want 0000", {r1_gnt, r0_gnt, dut_start, busy});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_ignore_done();
        test_stable_and_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
